pc_uart_streamer: RTL

- Sits between the data path and the UART core, upstream of the UART's byte interface.
- Merges two byte sources into the UART's single write port:
  - the CPU's own UART writes;
  - an automatic debug stream that sends the current PC as ASCII hex followed by an end-of-line each time the PC changes while streaming is enabled (sw_pc).
- Handles the UART busy handshake and reports a combined busy back to the data path.

---
 rtl/pc_uart_streamer_pkg.sv | 24 ++
 rtl/pc_uart_streamer_hex_nibble_ascii.sv | 17 +
 rtl/pc_uart_streamer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pc_uart_streamer_pkg.sv
// Shared types and constants for the PC-to-UART debug streamer.
// Holds the FSM state encoding and the ASCII constants used for framing.
package pc_uart_streamer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SEND  = ST_SEND,
        GUARD = ST_GUARD,
        WAIT  = ST_WAIT
    } state_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h37;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/pc_uart_streamer_hex_nibble_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_nibble_ascii
    import pc_uart_streamer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = ASCII_A_OFS + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/pc_uart_streamer.sv
// Merges CPU UART writes with an automatic PC hex dump stream
// into the single UART write port, handling the busy handshake.
module pc_uart_streamer
    import pc_uart_streamer_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter bit EOL_CRLF     = 1'b1,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] pc,
    input  logic [7:0]  cpu_tx_data,
    input  logic        cpu_tx_we,
    output logic        cpu_tx_busy,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_we,
    input  logic        uart_tx_busy,
    output logic        streaming,
    output logic        cpu_overrun
);

    localparam int FRAME_LEN = NUM_DIGITS + 1 + (EOL_CRLF ? 1 : 0);
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_LEN - 1);
    localparam logic [3:0] LAST_DIG   = 4'(NUM_DIGITS - 1);
    localparam logic [3:0] CR_IDX     = 4'(NUM_DIGITS);
    localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [7:0]  hold_q, hold_d;
    logic        sel_cpu_q, sel_cpu_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] snap_q, snap_d;
    logic        resend_q, resend_d;
    logic        en_q, en_d;
    logic        streaming_q, streaming_d;
    logic [3:0]  guard_q, guard_d;
    logic        overrun_q, overrun_d;

    logic        busy_int;
    logic        accept;
    logic        frame_req;
    logic [3:0]  dig;
    logic [5:0]  shamt;
    logic [3:0]  nibble;
    logic [7:0]  hex_byte;
    logic [7:0]  frame_byte;
    logic [7:0]  sel_byte;

    hex_nibble_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_byte)
    );

    // Digit idx maps to nibble NUM_DIGITS-1-idx of the snapshot (MSB first)
    always_comb begin
        dig    = LAST_DIG - idx_q;
        shamt  = {dig, 2'b00};
        nibble = 4'(snap_q >> shamt);
        if (idx_q < CR_IDX) begin
            frame_byte = hex_byte;
        end else if (EOL_CRLF && (idx_q == CR_IDX)) begin
            frame_byte = ASCII_CR;
        end else begin
            frame_byte = ASCII_LF;
        end
        sel_byte = sel_cpu_q ? hold_q : frame_byte;
    end

    always_comb begin
        busy_int  = pend_q | (state_q != IDLE) | uart_tx_busy;
        accept    = cpu_tx_we & ~busy_int;
        frame_req = enable & (resend_q | (pc != snap_q));

        state_d     = state_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        sel_cpu_d   = sel_cpu_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        resend_d    = resend_q | (enable & ~en_q);
        en_d        = enable;
        streaming_d = streaming_q;
        guard_d     = guard_q;
        overrun_d   = overrun_q | (cpu_tx_we & busy_int);

        if (accept) begin
            pend_d = 1'b1;
            hold_d = cpu_tx_data;
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    sel_cpu_d = 1'b1;
                    state_d   = LOAD;
                end else if (frame_req) begin
                    sel_cpu_d   = 1'b0;
                    snap_d      = pc;
                    resend_d    = 1'b0;
                    idx_d       = 4'd0;
                    streaming_d = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (!uart_tx_busy) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                guard_d = GUARD_INIT;
                state_d = GUARD;
            end
            GUARD: begin
                guard_d = guard_q - 4'd1;
                if (guard_d == 4'd0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!uart_tx_busy) begin
                    if (sel_cpu_q) begin
                        pend_d  = 1'b0;
                        state_d = IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        streaming_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            hold_q      <= 8'h00;
            sel_cpu_q   <= 1'b0;
            idx_q       <= 4'd0;
            snap_q      <= 32'h0;
            resend_q    <= 1'b1;
            en_q        <= 1'b0;
            streaming_q <= 1'b0;
            guard_q     <= 4'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            sel_cpu_q   <= sel_cpu_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            resend_q    <= resend_d;
            en_q        <= en_d;
            streaming_q <= streaming_d;
            guard_q     <= guard_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        cpu_tx_busy  = busy_int;
        uart_tx_we   = (state_q == SEND);
        uart_tx_data = (state_q == IDLE) ? 8'h00 : sel_byte;
        streaming    = streaming_q;
        cpu_overrun  = overrun_q;
    end

endmodule
